// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-walk scan, per-scan result classification,
// debounce over consecutive identical scans, one valid strobe per clean press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 4096,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(15);
  localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} res_e;
  typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_e;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_out;
  logic [1:0]       r_acc_hits;   // saturates at 2: only 0/1/many matters
  logic             r_acc_found;
  logic [3:0]       r_acc_code;
  res_e             r_prev_res;
  logic [3:0]       r_prev_code;
  logic [CNT_W-1:0] r_stable;
  state_e           r_state;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_sample;
  logic             w_scan_done;
  logic [2:0]       w_col_hits;
  logic [1:0]       w_col_sat;
  logic [1:0]       w_low_row;
  logic [2:0]       w_tot_sum;
  logic [1:0]       w_tot_hits;
  logic [3:0]       w_found_code;
  res_e             w_res;
  logic [3:0]       w_res_code;
  logic [CNT_W-1:0] w_stable_next;
  state_e           w_state_next;
  logic [3:0]       w_code_next;
  logic             w_valid_next;
  logic             w_held_next;

  assign w_sample    = (r_div == DIV_LAST);
  assign w_scan_done = w_sample && (r_col_idx == 2'd3);

  // Per-column row decode and running scan classification
  always_comb begin
    w_col_hits = 3'(!row_in[0]) + 3'(!row_in[1]) + 3'(!row_in[2]) + 3'(!row_in[3]);
    w_col_sat  = (w_col_hits > 3'd1) ? 2'd2 : w_col_hits[1:0];
    casez (row_in)
      4'b???0: w_low_row = 2'd0;
      4'b??01: w_low_row = 2'd1;
      4'b?011: w_low_row = 2'd2;
      default: w_low_row = 2'd3;
    endcase
    w_tot_sum    = 3'(r_acc_hits) + 3'(w_col_sat);
    w_tot_hits   = (w_tot_sum > 3'd1) ? 2'd2 : w_tot_sum[1:0];
    w_found_code = r_acc_found ? r_acc_code : {w_low_row, r_col_idx};
    case (w_tot_hits)
      2'd0:    w_res = RES_NONE;
      2'd1:    w_res = RES_KEY;
      default: w_res = RES_MULTI;
    endcase
    w_res_code = (w_res == RES_KEY) ? w_found_code : 4'd0;
    if ((w_res == r_prev_res) && (w_res_code == r_prev_code))
      w_stable_next = (r_stable == CNT_MAX) ? CNT_MAX : r_stable + CNT_W'(1);
    else
      w_stable_next = CNT_W'(1);
  end

  // Scan timing, accumulator and debounce history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_col_idx   <= 2'd0;
      r_col_out   <= 4'b1110;
      r_acc_hits  <= 2'd0;
      r_acc_found <= 1'b0;
      r_acc_code  <= 4'd0;
      r_prev_res  <= RES_NONE;
      r_prev_code <= 4'd0;
      r_stable    <= '0;
    end else begin
      r_div <= w_sample ? '0 : r_div + DIV_W'(1);
      if (w_sample) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_col_out <= {r_col_out[2:0], r_col_out[3]};
        if (w_scan_done) begin
          r_acc_hits  <= 2'd0;
          r_acc_found <= 1'b0;
          r_acc_code  <= 4'd0;
          r_prev_res  <= w_res;
          r_prev_code <= w_res_code;
          r_stable    <= w_stable_next;
        end else begin
          r_acc_hits <= w_tot_hits;
          if (!r_acc_found && (w_col_hits != 3'd0)) begin
            r_acc_found <= 1'b1;
            r_acc_code  <= {w_low_row, r_col_idx};
          end
        end
      end
    end
  end

  // Press/release FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_key_code  <= w_code_next;
      r_key_valid <= w_valid_next;
      r_key_held  <= w_held_next;
    end
  end

  // Next state: act only on scan-complete edges with the freshly updated count
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_key_code;
    w_valid_next = 1'b0;
    w_held_next  = r_key_held;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if ((w_res == RES_KEY) && (w_stable_next == DEB_CNT)) begin
            w_code_next  = w_res_code;
            w_valid_next = 1'b1;
            w_held_next  = 1'b1;
            w_state_next = S_HELD;
          end
        end
        S_HELD: begin
          if ((w_res == RES_NONE) && (w_stable_next == DEB_CNT)) begin
            w_held_next  = 1'b0;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
